// File: rtl/shift_unit_pkg.sv
// Shared encodings for the multi-bit universal shift register.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package shift_unit_pkg;

    typedef enum logic [2:0] {
        CMD_LOAD  = 3'd0,
        CMD_ROL   = 3'd1,
        CMD_ROR   = 3'd2,
        CMD_SHR   = 3'd3,
        CMD_SHL   = 3'd4,
        CMD_ASR   = 3'd5,
        CMD_CLEAR = 3'd6,
        CMD_NOP   = 3'd7
    } cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic is_shift(cmd_e c);
        return (c == CMD_ROL) || (c == CMD_ROR) || (c == CMD_SHR) ||
               (c == CMD_SHL) || (c == CMD_ASR);
    endfunction

    function automatic logic is_rotate(cmd_e c);
        return (c == CMD_ROL) || (c == CMD_ROR);
    endfunction

endpackage

// File: rtl/shift_unit_multi_if.sv
// Command/data bundle between a controller and shift_unit_multi.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready handshake, accept = cmd_valid & cmd_ready at clk rise.
// Ports: cmd_valid, cmd, amt, par_in, ser_in (controller -> unit);
//        cmd_ready, data_out, ser_out, busy, done (unit -> controller).
interface shift_unit_multi_if
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
);
    logic             cmd_valid;
    logic             cmd_ready;
    cmd_e             cmd;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] par_in;
    logic             ser_in;
    logic [WIDTH-1:0] data_out;
    logic             ser_out;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd, amt, par_in, ser_in,
        input  cmd_ready, data_out, ser_out, busy, done
    );

    modport slave (
        input  cmd_valid, cmd, amt, par_in, ser_in,
        output cmd_ready, data_out, ser_out, busy, done
    );
endinterface

// File: rtl/shift_unit_step.sv
// Single 1-bit shift/rotate step of the register contents.
// Latency: combinational.
// Backpressure: none.
// Ports: cmd, d, ser_in in; d_next (stepped data), bit_out (bit leaving the register) out.
//        Non-shift commands pass d through with bit_out = 0.
module shift_unit_step
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  cmd_e             cmd,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] d_next,
    output logic             bit_out
);
    always_comb begin
        d_next  = d;
        bit_out = 1'b0;
        case (cmd)
            CMD_ROL: begin
                d_next  = {d[WIDTH-2:0], d[WIDTH-1]};
                bit_out = d[WIDTH-1];
            end
            CMD_ROR: begin
                d_next  = {d[0], d[WIDTH-1:1]};
                bit_out = d[0];
            end
            CMD_SHR: begin
                d_next  = {ser_in, d[WIDTH-1:1]};
                bit_out = d[0];
            end
            CMD_SHL: begin
                d_next  = {d[WIDTH-2:0], ser_in};
                bit_out = d[WIDTH-1];
            end
            CMD_ASR: begin
                d_next  = {d[WIDTH-1], d[WIDTH-1:1]};
                bit_out = d[0];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/shift_unit_multi.sv
// Universal shift register with multi-bit amount, serial in/out and done pulse.
// Latency: LOAD/CLEAR/NOP/amt=0 and (barrel) all shifts finish on the accept edge;
//          iterative shifts of k finish k-1 edges later; done is high the cycle after.
// Backpressure: cmd_ready low (busy high) while an iterative shift is running.
// Ports: clk, rst (async, active-low), bus (shift_unit_multi_if.slave).
// Option: define SHIFT_UNIT_BARREL_EN for a single-edge barrel network instead of stepping.
module shift_unit_multi
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    shift_unit_multi_if.slave  bus
);
    state_e           st_q, st_n;
    logic [AMT_W-1:0] cnt_q, cnt_n;   // steps still to apply while in RUN
    cmd_e             op_q, op_n;     // shift captured at accept, replayed in RUN
    logic [WIDTH-1:0] data_q, data_n;
    logic             ser_q, ser_n;
    logic             done_q, done_n;

    logic             accept;
    cmd_e             step_cmd;
    logic [WIDTH-1:0] step_d;
    logic             step_bit;
    logic [AMT_W-1:0] k;

    // Out-of-range amounts: rotates wrap, shifts saturate to WIDTH-1.
    function automatic logic [AMT_W-1:0] eff_amt(cmd_e c, logic [AMT_W-1:0] a);
        int ai;
        ai = int'({1'b0, a});
        if (ai < WIDTH)
            return a;
        else if (is_rotate(c))
            return AMT_W'(ai % WIDTH);
        else
            return AMT_W'(WIDTH - 1);
    endfunction

    assign accept   = bus.cmd_valid & bus.cmd_ready;
    assign k        = eff_amt(bus.cmd, bus.amt);
    // In RUN the step replays the captured op; in IDLE it previews the incoming one.
    assign step_cmd = (st_q == ST_RUN) ? op_q : bus.cmd;

    shift_unit_step #(.WIDTH(WIDTH)) u_step (
        .cmd     (step_cmd),
        .d       (data_q),
        .ser_in  (bus.ser_in),
        .d_next  (step_d),
        .bit_out (step_bit)
    );

`ifdef SHIFT_UNIT_BARREL_EN
    logic [WIDTH-1:0]   bar_d;
    logic               bar_bit;
    logic [WIDTH-1:0]   fill;
    logic [2*WIDTH:0]   cat;

    // Data is flanked by the fill word and one guard bit; after shifting by k the
    // guard position holds the last bit pushed out of the register.
    always_comb begin
        fill    = '0;
        cat     = '0;
        bar_d   = data_q;
        bar_bit = 1'b0;
        case (bus.cmd)
            CMD_ROL, CMD_ROR: fill = data_q;
            CMD_SHR, CMD_SHL: fill = {WIDTH{bus.ser_in}};
            CMD_ASR:          fill = {WIDTH{data_q[WIDTH-1]}};
            default:          fill = '0;
        endcase
        case (bus.cmd)
            CMD_ROL, CMD_SHL: begin
                cat     = {1'b0, data_q, fill} << k;
                bar_d   = cat[2*WIDTH-1:WIDTH];
                bar_bit = cat[2*WIDTH];
            end
            CMD_ROR, CMD_SHR, CMD_ASR: begin
                cat     = {fill, data_q, 1'b0} >> k;
                bar_d   = cat[WIDTH:1];
                bar_bit = cat[0];
            end
            default: ;
        endcase
    end
`endif

    always_comb begin
        st_n   = st_q;
        cnt_n  = cnt_q;
        op_n   = op_q;
        data_n = data_q;
        ser_n  = ser_q;
        done_n = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.cmd)
                        CMD_LOAD: begin
                            data_n = bus.par_in;
                            done_n = 1'b1;
                        end
                        CMD_CLEAR: begin
                            data_n = '0;
                            done_n = 1'b1;
                        end
                        CMD_NOP: done_n = 1'b1;
                        default: begin
                            if (k == '0) begin
                                done_n = 1'b1;
                            end else begin
`ifdef SHIFT_UNIT_BARREL_EN
                                data_n = bar_d;
                                ser_n  = bar_bit;
                                done_n = 1'b1;
`else
                                data_n = step_d;
                                ser_n  = step_bit;
                                op_n   = bus.cmd;
                                if (k == AMT_W'(1)) begin
                                    done_n = 1'b1;
                                end else begin
                                    st_n  = ST_RUN;
                                    cnt_n = k - AMT_W'(1);
                                end
`endif
                            end
                        end
                    endcase
                end
            end
            ST_RUN: begin
                data_n = step_d;
                ser_n  = step_bit;
                cnt_n  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    st_n   = ST_IDLE;
                    done_n = 1'b1;
                end
            end
            default: st_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            op_q   <= CMD_NOP;
            data_q <= '0;
            ser_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_n;
            cnt_q  <= cnt_n;
            op_q   <= op_n;
            data_q <= data_n;
            ser_q  <= ser_n;
            done_q <= done_n;
        end
    end

    assign bus.cmd_ready = (st_q == ST_IDLE);
    assign bus.busy      = (st_q == ST_RUN);
    assign bus.data_out  = data_q;
    assign bus.ser_out   = ser_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_shift_unit_multi.sv
// Scoreboard bench for shift_unit_multi: expected data/ser_out/done cycle queued at
// accept, popped and compared on every done pulse.
module tb_shift_unit_multi;
    import shift_unit_pkg::*;

    localparam int W  = 8;
    localparam int AW = 3;
`ifdef SHIFT_UNIT_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] data;
        logic         ser;
        int           cyc;
    } exp_t;

    logic clk;
    logic rst;
    shift_unit_multi_if #(.WIDTH(W), .AMT_W(AW)) bus ();

    shift_unit_multi #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   busy_cnt = 0;
    exp_t sb_q[$];
    logic [W-1:0] m_data = '0;
    logic         m_ser  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference 1-bit step, written independently from the RTL.
    function automatic logic [W-1:0] m_step(cmd_e c, logic [W-1:0] d, logic s, output logic b);
        logic [W-1:0] r;
        r = d;
        b = 1'b0;
        case (c)
            CMD_ROL: begin b = d[W-1]; r = (d << 1) | (d >> (W-1)); end
            CMD_ROR: begin b = d[0];   r = (d >> 1) | (d << (W-1)); end
            CMD_SHR: begin b = d[0];   r = (d >> 1); r[W-1] = s; end
            CMD_SHL: begin b = d[W-1]; r = (d << 1); r[0] = s; end
            CMD_ASR: begin b = d[0];   r = (d >> 1); r[W-1] = d[W-1]; end
            default: ;
        endcase
        return r;
    endfunction

    // Apply a command to the model and queue its expected completion.
    // Called at the negedge just before the accepting posedge.
    task automatic sb_push(input cmd_e c, input int a, input logic [W-1:0] p,
                           input logic [W-1:0] pat, output int steps);
        exp_t e;
        logic b;
        steps = 0;
        case (c)
            CMD_LOAD:  m_data = p;
            CMD_CLEAR: m_data = '0;
            CMD_NOP:   ;
            default: begin
                steps = a;
                for (int i = 0; i < a; i++) begin
                    m_data = m_step(c, m_data, BARREL ? pat[0] : pat[i], b);
                    m_ser  = b;
                end
            end
        endcase
        e.data = m_data;
        e.ser  = m_ser;
        e.cyc  = cyc + 1 + ((BARREL || steps == 0) ? 0 : steps - 1);
        sb_q.push_back(e);
    endtask

    // Drive one command; pat[i] is ser_in for step i+1. Returns at the negedge
    // after the last step (or right after accept when keep_vld is set).
    task automatic issue(input cmd_e c, input int a, input logic [W-1:0] p,
                         input logic [W-1:0] pat, input bit keep_vld, output int waited);
        int steps;
        waited = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.amt       = AW'(a);
        bus.par_in    = p;
        bus.ser_in    = pat[0];
        while (!bus.cmd_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 64) begin
                chk("accept_timeout", 32'(bus.cmd_ready), 32'd1);
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        sb_push(c, a, p, pat, steps);
        @(posedge clk);
        @(negedge clk);
        if (keep_vld) return;
        bus.cmd_valid = 1'b0;
        if (!BARREL) begin
            for (int i = 1; i < steps; i++) begin
                bus.ser_in = pat[i];
                @(negedge clk);
            end
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            chk("busy_vs_rdy", 32'(bus.busy), 32'(!bus.cmd_ready));
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_done", 32'(bus.done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_data", 32'(bus.data_out), 32'(e.data));
                    chk("sb_ser",  32'(bus.ser_out),  32'(e.ser));
                    chk("sb_done_cyc", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        int w;
        int dummy;
        logic s;
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd       = CMD_NOP;
        bus.amt       = '0;
        bus.par_in    = '0;
        bus.ser_in    = 1'b0;
        #3;
        chk("rst_data",  32'(bus.data_out),  32'h0);
        chk("rst_ser",   32'(bus.ser_out),   32'h0);
        chk("rst_done",  32'(bus.done),      32'h0);
        chk("rst_busy",  32'(bus.busy),      32'h0);
        chk("rst_ready", 32'(bus.cmd_ready), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset in the middle of a running rotate.
        issue(CMD_LOAD, 0, 8'hA5, 8'h00, 1'b0, dummy);
        bus.cmd_valid = 1'b1;
        bus.cmd       = CMD_ROL;
        bus.amt       = AW'(5);
        if (BARREL) sb_push(CMD_ROL, 5, 8'h00, 8'h00, dummy);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t1_data",  32'(bus.data_out),  32'h0);
        chk("t1_busy",  32'(bus.busy),      32'h0);
        chk("t1_done",  32'(bus.done),      32'h0);
        chk("t1_ready", 32'(bus.cmd_ready), 32'h1);
        m_data = '0;
        m_ser  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // ROR 3 of A5.
        issue(CMD_LOAD, 0, 8'hA5, 8'h00, 1'b0, dummy);
        busy_cnt = 0;
        issue(CMD_ROR, 3, 8'h00, 8'h00, 1'b0, dummy);
        chk("t2_data", 32'(bus.data_out), 32'hB4);
        chk("t2_ser",  32'(bus.ser_out),  32'h1);
        chk("t2_done", 32'(bus.done),     32'h1);
        chk("t2_busy_cycles", 32'(busy_cnt), BARREL ? 32'd0 : 32'd2);

        // ASR then SHL with serial fill.
        issue(CMD_LOAD, 0, 8'h81, 8'h00, 1'b0, dummy);
        issue(CMD_ASR, 2, 8'h00, 8'h00, 1'b0, dummy);
        chk("t3_asr", 32'(bus.data_out), 32'hE0);
        issue(CMD_SHL, 1, 8'h00, 8'hFF, 1'b0, dummy);
        chk("t3_shl", 32'(bus.data_out), 32'hC1);
        chk("t3_ser", 32'(bus.ser_out),  32'h1);

        // SHR 4 from zero, live serial input.
        issue(CMD_CLEAR, 0, 8'h00, 8'h00, 1'b0, dummy);
        issue(CMD_SHR, 4, 8'h00, BARREL ? 8'hFF : 8'h05, 1'b0, dummy);
        chk("t4_shr", 32'(bus.data_out), BARREL ? 32'hF0 : 32'h50);

        // Back-to-back single-cycle commands; done cycles checked by the scoreboard.
        issue(CMD_LOAD,  0, 8'h3C, 8'h00, 1'b0, dummy);
        issue(CMD_NOP,   0, 8'hFF, 8'h00, 1'b0, dummy);
        issue(CMD_CLEAR, 0, 8'hFF, 8'h00, 1'b0, dummy);
        chk("t5_data", 32'(bus.data_out), 32'h0);

        // Valid held through busy, then a zero-distance rotate.
        issue(CMD_LOAD, 0, 8'h5A, 8'h00, 1'b0, dummy);
        issue(CMD_ROL, 3, 8'h00, 8'h00, 1'b1, dummy);
        issue(CMD_ROL, 0, 8'h00, 8'h00, 1'b0, w);
        chk("t6_wait", 32'(w), BARREL ? 32'd0 : 32'd2);
        chk("t6_data", 32'(bus.data_out), 32'hD2);
        chk("t6_done", 32'(bus.done), 32'h1);

        // Random mix, ser_in held constant per command.
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            issue(cmd_e'($urandom_range(0, 7)), int'($urandom_range(0, W-1)),
                  W'($urandom), {W{s}}, 1'b0, dummy);
            chk("rnd_model", 32'(bus.data_out), 32'(m_data));
        end

        repeat (12) @(negedge clk);
        chk("sb_empty",   32'(sb_q.size()), 32'd0);
        chk("final_busy", 32'(bus.busy),    32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
